md_unit: RTL

Parametrised multiply/divide unit with HI/LO registers, sitting in the E stage beside the ALU. It generalises the fixed-latency mult/div block in four ways: independent multiply and divide latencies, configurable operand width, multiply-accumulate/subtract ops, and an abort input for future exception flushing. The hazard unit stalls D-stage HI/LO users while `busy` is high, and for the cycle in which `start` is asserted.

---
 rtl/md_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO registers, E stage.
// Multiply-class ops and divides have independent fixed latencies. The unit
// also supports multiply-accumulate/subtract and a cancel input that discards
// an in-flight op without touching HI/LO.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no op in flight; mthi/mtlo writes and new starts are accepted
// RUN   | op in flight; counter counts down, commit when it reaches 1
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int W2         = 2 * WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             op_signed;
  logic             is_div;
  logic             is_acc;
  logic             is_sub;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    b_ext;
  logic [W2-1:0]    product;
  logic [W2-1:0]    acc_res;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Result datapath, evaluated from the latched operands and current HI/LO.
  always_comb begin
    op_signed = ~op_q[0];
    is_div    = (op_q[2:1] == 2'b01);
    is_acc    = op_q[2];
    is_sub    = op_q[2] & op_q[1];

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product
    // are then correct for both signed and unsigned operands.
    a_ext   = op_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext   = op_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product = a_ext * b_ext;

    if (is_acc) begin
      acc_res = is_sub ? ({hi, lo} - product) : ({hi, lo} + product);
    end else begin
      acc_res = product;
    end

    // Divide on magnitudes, then fix signs. The most negative dividend
    // over -1 falls out naturally as quotient 0x80..0, remainder 0.
    a_neg  = op_signed & a_q[WIDTH-1];
    b_neg  = op_signed & b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_safe = (b_q == '0) ? WIDTH'(1) : b_mag;
    uq     = a_mag / b_safe;
    ur     = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -uq : uq;
    rem    = a_neg ? -ur : ur;
    if (b_q == '0) begin
      quo = '1;
      rem = a_q;
    end

    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = acc_res[W2-1:WIDTH];
      res_lo = acc_res[WIDTH-1:0];
    end
  end

  // Control FSM, operand capture and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op_q  <= op;
              a_q   <= src_a;
              b_q   <= src_b;
              cnt   <= (op[2:1] == 2'b01) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              if (hi_we) hi <= src_a;
              if (lo_we) lo <= src_a;
            end
          end
          RUN: begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              hi    <= res_hi;
              lo    <= res_lo;
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
